// File: rtl/mod_down_single.sv
// Multi-cycle RNS ModDown: x in basis Q u P -> x/P in basis Q via fast base conversion of the P residues.
// Define MOD_DOWN_ROUND_EN to add floor(P/2) to the inputs on accept (rounding instead of flooring).
package mod_down_single_pkg;
  typedef logic [15:0] rns_residue_t;
endpackage

module mod_down_single
  import mod_down_single_pkg::*;
#(
  parameter int           Q_LEN = 2,
  parameter int           P_LEN = 2,
  parameter rns_residue_t Q_BASIS    [Q_LEN]        = '{default: 0},
  parameter rns_residue_t P_BASIS    [P_LEN]        = '{default: 0},
  parameter rns_residue_t ZiLUT      [P_LEN]        = '{default: 0},
  parameter rns_residue_t YMODQ      [Q_LEN][P_LEN] = '{default: 0},
  parameter rns_residue_t PINV_MODQ  [Q_LEN]        = '{default: 0},
  parameter rns_residue_t HALFP_MODP [P_LEN]        = '{default: 0},
  parameter rns_residue_t HALFP_MODQ [Q_LEN]        = '{default: 0}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  rns_residue_t in_q          [Q_LEN],
  input  rns_residue_t in_p          [P_LEN],
  output logic         out_valid,
  output rns_residue_t output_RNSint [Q_LEN],
  output logic         busy
);
  localparam int W     = $bits(rns_residue_t);
  localparam int IDX_W = (P_LEN > 1) ? $clog2(P_LEN) : 1;
  typedef logic [2*W-1:0]   wide_t;
  typedef logic [W:0]       sum_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONV  = 2'd1;
  localparam logic [1:0] ST_SCALE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  if (Q_BASIS[0] == 0 || P_BASIS[0] == 0 || ZiLUT[0] == 0) begin : g_bad_cfg
    $fatal(1, "mod_down_single: Q_BASIS[0], P_BASIS[0] and ZiLUT[0] must be non-zero");
  end

  logic [1:0]   state_q, state_d;
  idx_t         idx_q, idx_d;
  rns_residue_t acc_q [Q_LEN];
  rns_residue_t acc_d [Q_LEN];
  rns_residue_t xq_q  [Q_LEN];
  rns_residue_t xq_d  [Q_LEN];
  rns_residue_t a_q   [P_LEN];
  rns_residue_t a_d   [P_LEN];
  rns_residue_t res_q [Q_LEN];
  rns_residue_t res_d [Q_LEN];

  rns_residue_t a_in      [P_LEN];
  rns_residue_t xq_in     [Q_LEN];
  rns_residue_t acc_step  [Q_LEN];
  rns_residue_t res_scale [Q_LEN];
  rns_residue_t a_sel;

  genvar gi;

  // Accept-side P lanes: a_i = x_i * (P/p_i)^-1 mod p_i.
  for (gi = 0; gi < P_LEN; gi++) begin : g_p
    rns_residue_t p_src;
`ifdef MOD_DOWN_ROUND_EN
    sum_t p_sum;
    assign p_sum = {1'b0, in_p[gi]} + {1'b0, HALFP_MODP[gi]};
    assign p_src = (p_sum >= {1'b0, P_BASIS[gi]}) ? rns_residue_t'(p_sum - {1'b0, P_BASIS[gi]})
                                                  : p_sum[W-1:0];
`else
    assign p_src = in_p[gi];
`endif
    assign a_in[gi] = rns_residue_t'((wide_t'(p_src) * wide_t'(ZiLUT[gi])) % wide_t'(P_BASIS[gi]));
  end

`ifndef MOD_DOWN_ROUND_EN
  logic unused_halfp;
  assign unused_halfp = ^{HALFP_MODP[0], HALFP_MODQ[0]};
`endif

  assign a_sel = a_q[idx_q];

  // Q lanes: one conversion term per CONV cycle, then (x_q - acc) * P^-1 in SCALE.
  for (gi = 0; gi < Q_LEN; gi++) begin : g_q
    rns_residue_t q_src, prod, d;
    sum_t         acc_sum;
`ifdef MOD_DOWN_ROUND_EN
    sum_t q_sum;
    assign q_sum = {1'b0, in_q[gi]} + {1'b0, HALFP_MODQ[gi]};
    assign q_src = (q_sum >= {1'b0, Q_BASIS[gi]}) ? rns_residue_t'(q_sum - {1'b0, Q_BASIS[gi]})
                                                  : q_sum[W-1:0];
`else
    assign q_src = in_q[gi];
`endif
    assign xq_in[gi] = q_src;
    assign prod = rns_residue_t'((wide_t'(a_sel) * wide_t'(YMODQ[gi][idx_q])) % wide_t'(Q_BASIS[gi]));
    assign acc_sum = {1'b0, acc_q[gi]} + {1'b0, prod};
    assign acc_step[gi] = (acc_sum >= {1'b0, Q_BASIS[gi]}) ? rns_residue_t'(acc_sum - {1'b0, Q_BASIS[gi]})
                                                           : acc_sum[W-1:0];
    assign d = (xq_q[gi] >= acc_q[gi]) ? rns_residue_t'(xq_q[gi] - acc_q[gi])
             : rns_residue_t'(sum_t'(xq_q[gi]) + sum_t'(Q_BASIS[gi]) - sum_t'(acc_q[gi]));
    assign res_scale[gi] = rns_residue_t'((wide_t'(d) * wide_t'(PINV_MODQ[gi])) % wide_t'(Q_BASIS[gi]));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    xq_d    = xq_q;
    a_d     = a_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (in_valid) begin
          xq_d    = xq_in;
          a_d     = a_in;
          acc_d   = '{default: '0};
          idx_d   = '0;
          state_d = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        acc_d = acc_step;
        idx_d = idx_q + 1'b1;
        if (idx_q == idx_t'(P_LEN - 1)) state_d = ST_SCALE;
      end
      ST_SCALE: begin
        res_d   = res_scale;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '{default: '0};
      xq_q    <= '{default: '0};
      a_q     <= '{default: '0};
      res_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      xq_q    <= xq_d;
      a_q     <= a_d;
      res_q   <= res_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy          = (state_q == ST_CONV) || (state_q == ST_SCALE);
  assign out_valid     = (state_q == ST_DONE);
  assign output_RNSint = res_q;
endmodule

// File: tb/tb_mod_down_single.sv
// Directed bench for mod_down_single with Q={11,13}, P={5,7}; expected results hand-computed.
module tb_mod_down_single;
  import mod_down_single_pkg::*;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  rns_residue_t in_q          [2];
  rns_residue_t in_p          [2];
  rns_residue_t output_RNSint [2];

  int checks   = 0;
  int failures = 0;

`ifdef MOD_DOWN_ROUND_EN
  localparam rns_residue_t E353_0 = 10, E353_1 = 10, E368_0 = 0, E368_1 = 11;
`else
  localparam rns_residue_t E353_0 = 9,  E353_1 = 9,  E368_0 = 9, E368_1 = 9;
`endif

  mod_down_single #(
    .Q_LEN      (2),
    .P_LEN      (2),
    .Q_BASIS    ('{11, 13}),
    .P_BASIS    ('{5, 7}),
    .ZiLUT      ('{3, 3}),
    .YMODQ      ('{'{7, 5}, '{7, 5}}),
    .PINV_MODQ  ('{6, 3}),
    .HALFP_MODP ('{2, 3}),
    .HALFP_MODQ ('{6, 4})
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_q          (in_q),
    .in_p          (in_p),
    .out_valid     (out_valid),
    .output_RNSint (output_RNSint),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request from IDLE and wait (bounded) for the result pulse.
  task automatic run_op(input rns_residue_t q0, input rns_residue_t q1,
                        input rns_residue_t p0, input rns_residue_t p1,
                        output int lat, output rns_residue_t r0, output rns_residue_t r1);
    in_q[0] = q0; in_q[1] = q1; in_p[0] = p0; in_p[1] = p1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1; r0 = '0; r1 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c; r0 = output_RNSint[0]; r1 = output_RNSint[1];
        break;
      end
    end
    $display("op q={%0d,%0d} p={%0d,%0d} -> result={%0d,%0d} latency=%0d", q0, q1, p0, p1, r0, r1, lat);
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0;
    in_q[0] = '0; in_q[1] = '0; in_p[0] = '0; in_p[1] = '0;
    #3 reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (output_RNSint[0] !== 16'd0 || output_RNSint[1] !== 16'd0) begin
      failures++; $display("FAIL reset_output: got {%0d,%0d} expected {0,0}", output_RNSint[0], output_RNSint[1]);
    end
    reset = 1'b1;
  endtask

  task automatic test_idle;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || output_RNSint[0] !== 16'd0 || output_RNSint[1] !== 16'd0) begin
        failures++;
        $display("FAIL idle_cycle%0d: got out_valid=%b busy=%b out={%0d,%0d} expected 0,0,{0,0}",
                 c, out_valid, busy, output_RNSint[0], output_RNSint[1]);
      end
    end
  endtask

  task automatic test_basic;
    int lat; rns_residue_t r0, r1;
    run_op(16'd9, 16'd12, 16'd0, 16'd0, lat, r0, r1);
    checks++; if (lat !== 3) begin failures++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    checks++; if (r0 !== 16'd10 || r1 !== 16'd10) begin failures++; $display("FAIL basic_result: got {%0d,%0d} expected {10,10}", r0, r1); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_width: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_back_idle: got %b expected 1", in_ready); end
    checks++; if (output_RNSint[0] !== 16'd10 || output_RNSint[1] !== 16'd10) begin
      failures++; $display("FAIL basic_hold: got {%0d,%0d} expected {10,10}", output_RNSint[0], output_RNSint[1]);
    end
  endtask

  task automatic test_overflow_e1;
    int lat; rns_residue_t r0, r1;
    run_op(16'd1, 16'd2, 16'd3, 16'd3, lat, r0, r1);
    checks++; if (lat !== 3) begin failures++; $display("FAIL e1_latency: got %0d expected 3", lat); end
    checks++; if (r0 !== E353_0 || r1 !== E353_1) begin
      failures++; $display("FAIL e1_result: got {%0d,%0d} expected {%0d,%0d}", r0, r1, E353_0, E353_1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round;
    int lat; rns_residue_t r0, r1;
    run_op(16'd5, 16'd4, 16'd3, 16'd4, lat, r0, r1);
    checks++; if (lat !== 3) begin failures++; $display("FAIL round_latency: got %0d expected 3", lat); end
    checks++; if (r0 !== E368_0 || r1 !== E368_1) begin
      failures++; $display("FAIL round_result: got {%0d,%0d} expected {%0d,%0d}", r0, r1, E368_0, E368_1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    in_q[0] = 16'd9; in_q[1] = 16'd12; in_p[0] = 16'd0; in_p[1] = 16'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_busy_after_accept: got busy=%b in_ready=%b expected 1,0", busy, in_ready);
    end
    @(posedge clk); #1;
    in_q[0] = 16'd1; in_q[1] = 16'd2; in_p[0] = 16'd3; in_p[1] = 16'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_scale_no_valid: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid: got %b expected 1", out_valid); end
    checks++; if (output_RNSint[0] !== 16'd10 || output_RNSint[1] !== 16'd10) begin
      failures++; $display("FAIL b2b_first_result: got {%0d,%0d} expected {10,10}", output_RNSint[0], output_RNSint[1]);
    end
    $display("op b2b first -> result={%0d,%0d}", output_RNSint[0], output_RNSint[1]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_no_idle_gap: got busy=%b expected 1", busy); end
    lat = -1;
    for (int c = 2; c <= 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = c; break; end
    end
    $display("op b2b second -> result={%0d,%0d} cycles=%0d", output_RNSint[0], output_RNSint[1], lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_spacing: got %0d expected 4", lat); end
    checks++; if (output_RNSint[0] !== E353_0 || output_RNSint[1] !== E353_1) begin
      failures++; $display("FAIL b2b_second_result: got {%0d,%0d} expected {%0d,%0d}",
                           output_RNSint[0], output_RNSint[1], E353_0, E353_1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat; rns_residue_t r0, r1;
    in_q[0] = 16'd1; in_q[1] = 16'd2; in_p[0] = 16'd3; in_p[1] = 16'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_in_scale: got busy=%b expected 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_flags: got in_ready=%b busy=%b out_valid=%b expected 1,0,0", in_ready, busy, out_valid);
    end
    checks++; if (output_RNSint[0] !== 16'd0 || output_RNSint[1] !== 16'd0) begin
      failures++; $display("FAIL rstmid_output: got {%0d,%0d} expected {0,0}", output_RNSint[0], output_RNSint[1]);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 2) reset = 1'b1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_pulse%0d: got %b expected 0", c, out_valid); end
    end
    run_op(16'd9, 16'd12, 16'd0, 16'd0, lat, r0, r1);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rstmid_after_latency: got %0d expected 3", lat); end
    checks++; if (r0 !== 16'd10 || r1 !== 16'd10) begin
      failures++; $display("FAIL rstmid_after_result: got {%0d,%0d} expected {10,10}", r0, r1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_overflow_e1();
    test_round();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
